// File: rtl/systola_pkg.sv
// Shared types and constants for the systola input-memory read path.
package systola_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } state_t;

    localparam int MEM_DATA_W = 8;
    localparam int MEM_RD_LAT = 1;

    // One read can be in the memory pipeline per latency cycle, plus the one on the bus.
    localparam int PEND_MAX = MEM_RD_LAT + 1;
    localparam int PEND_W   = $clog2(PEND_MAX + 1);

endpackage

// File: rtl/stream_fifo.sv
// Synchronous FIFO with occupancy output; push and pop may happen in the same cycle.
module stream_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] storage [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop   = pop && (count != '0);
    assign do_push  = push && ((count < CNT_W'(DEPTH)) || do_pop);
    assign pop_data = storage[rd_ptr];

    // Storage is cleared on reset so the head reads 0 until the first write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                storage[i] <= '0;
            end
        end else begin
            if (do_push) begin
                storage[wr_ptr] <= push_data;
                wr_ptr          <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/inpmem_streamer.sv
// Burst reader for the input memory bank, streaming returned bytes in address order.
// Optional INPMEM_STREAM_STRIDE_EN adds a per-burst address stride input.
module inpmem_streamer
    import systola_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int LEN_W      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic [LEN_W-1:0]      length,
`ifdef INPMEM_STREAM_STRIDE_EN
    input  logic [ADDR_W-1:0]     stride,
`endif
    output logic                  busy,
    output logic                  done,
    output logic                  mem_cen,
    output logic                  mem_wen,
    output logic [ADDR_W-1:0]     mem_a,
    output logic [MEM_DATA_W-1:0] mem_d,
    input  logic [MEM_DATA_W-1:0] mem_q,
    output logic [MEM_DATA_W-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int SUM_W = CNT_W + 1;

    state_t                  state_q, state_d;
    logic [LEN_W-1:0]        remaining_q;
    logic [ADDR_W-1:0]       mem_a_q;
    logic                    mem_cen_q;
    logic                    mem_wen_q;
    logic [MEM_DATA_W-1:0]   mem_d_q;
    logic [PEND_W-1:0]       pend_q;
    logic [MEM_RD_LAT-1:0]   rd_pipe_q;
    logic                    zero_done_q, zero_done_d;
    logic                    schedule, load, drain_done;
    logic                    issue, push, pop, room;
    logic [CNT_W-1:0]        fifo_count;
    logic [CNT_W-1:0]        next_occ;
    logic [SUM_W-1:0]        committed;
    logic [ADDR_W-1:0]       step;

    assign issue = !mem_cen_q;
    assign push  = rd_pipe_q[MEM_RD_LAT-1];
    assign pop   = out_valid && out_ready;

    // Space check looks one edge ahead because the memory drives come from flops.
    assign next_occ  = fifo_count + CNT_W'(push) - CNT_W'(pop);
    assign committed = SUM_W'(next_occ) + SUM_W'(pend_q) - SUM_W'(push);
    assign room      = committed < SUM_W'(FIFO_DEPTH);

`ifdef INPMEM_STREAM_STRIDE_EN
    logic [ADDR_W-1:0] stride_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stride_q <= ADDR_W'(1);
        end else if (load) begin
            stride_q <= stride;
        end
    end

    assign step = stride_q;
`else
    assign step = ADDR_W'(1);
`endif

    always_comb begin
        state_d     = state_q;
        schedule    = 1'b0;
        load        = 1'b0;
        zero_done_d = 1'b0;
        drain_done  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (length != '0) begin
                        load     = 1'b1;
                        schedule = 1'b1;
                        state_d  = ISSUE;
                    end else begin
                        zero_done_d = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (remaining_q == '0) begin
                    state_d = DRAIN;
                end else if (room) begin
                    schedule = 1'b1;
                end
            end
            DRAIN: begin
                if (pend_q == '0 && fifo_count == CNT_W'(1) && pop) begin
                    drain_done = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            mem_a_q     <= '0;
            mem_cen_q   <= 1'b1;
            mem_wen_q   <= 1'b1;
            mem_d_q     <= '0;
            pend_q      <= '0;
            rd_pipe_q   <= '0;
            zero_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            zero_done_q <= zero_done_d;
            mem_cen_q   <= !schedule;
            mem_wen_q   <= 1'b1;
            mem_d_q     <= '0;
            pend_q      <= pend_q + PEND_W'(schedule) - PEND_W'(push);
            rd_pipe_q[0] <= issue;
            for (int i = 1; i < MEM_RD_LAT; i++) begin
                rd_pipe_q[i] <= rd_pipe_q[i-1];
            end
            if (load) begin
                mem_a_q     <= base_addr;
                remaining_q <= length - LEN_W'(1);
            end else if (schedule) begin
                mem_a_q     <= mem_a_q + step;
                remaining_q <= remaining_q - LEN_W'(1);
            end
        end
    end

    stream_fifo #(
        .WIDTH (MEM_DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (mem_q),
        .pop       (pop),
        .pop_data  (out_data),
        .count     (fifo_count)
    );

    assign out_valid = fifo_count != '0;
    assign busy      = state_q != IDLE;
    assign done      = zero_done_q || drain_done;
    assign mem_cen   = mem_cen_q;
    assign mem_wen   = mem_wen_q;
    assign mem_a     = mem_a_q;
    assign mem_d     = mem_d_q;

endmodule

// File: tb/tb_inpmem_streamer.sv
// Directed bench for inpmem_streamer: vector table of bursts plus hand-written corner sequences.
module tb_inpmem_streamer;

    typedef struct {
        logic [15:0] base;
        logic [15:0] len;
        logic [15:0] stride;
        int          ready_mode;
        int          restart_at;
        int          exp_done;
    } vec_t;

    localparam int BUDGET = 400;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] base_addr;
    logic [15:0] length;
`ifdef INPMEM_STREAM_STRIDE_EN
    logic [15:0] stride;
`endif
    logic        busy, done, mem_cen, mem_wen, out_valid, out_ready;
    logic [15:0] mem_a;
    logic [7:0]  mem_d, out_data;
    logic [7:0]  mem_q = 8'h00;

    int errors = 0;
    int checks = 0;

    int          done_cnt, done_cyc, first_valid, busy_fall, max_inflight, hold_err, wen_err;
    bit          seen_busy, prev_stall;
    logic [7:0]  prev_data;
    logic [15:0] addr_log[$];
    logic [7:0]  data_log[$];
    vec_t        vecs[$];

    always #5 clk = ~clk;

    // Memory model: byte at each address equals its low address byte, one-cycle read latency.
    always @(posedge clk) begin
        if (!mem_cen) mem_q <= mem_a[7:0];
    end

    inpmem_streamer dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
`ifdef INPMEM_STREAM_STRIDE_EN
        .stride    (stride),
`endif
        .busy      (busy),
        .done      (done),
        .mem_cen   (mem_cen),
        .mem_wen   (mem_wen),
        .mem_a     (mem_a),
        .mem_d     (mem_d),
        .mem_q     (mem_q),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic readyFor(input int mode, input int r);
        case (mode)
            1:       return (r % 4 == 0) || (r % 4 == 3);
            2:       return r >= 12;
            default: return 1'b1;
        endcase
    endfunction

    task automatic clearLogs();
        done_cnt = 0; done_cyc = -1; first_valid = -1; busy_fall = -1;
        max_inflight = 0; hold_err = 0; wen_err = 0;
        seen_busy = 0; prev_stall = 0; prev_data = 8'h00;
        addr_log.delete();
        data_log.delete();
    endtask

    // Called at the falling edge, away from the DUT's active edge.
    task automatic sampleCycle(input int r);
        int inflight;
        if (!mem_cen) addr_log.push_back(mem_a);
        if (out_valid && first_valid < 0) first_valid = r;
        if (prev_stall && (!out_valid || out_data !== prev_data)) hold_err++;
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        if (out_valid && out_ready) data_log.push_back(out_data);
        if (done) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = r;
        end
        if (busy) seen_busy = 1;
        else if (seen_busy && busy_fall < 0) busy_fall = r;
        if (mem_wen !== 1'b1 || mem_d !== 8'h00) wen_err++;
        inflight = addr_log.size() - data_log.size();
        if (inflight > max_inflight) max_inflight = inflight;
    endtask

    task automatic applyStimulus(input vec_t v, input string tag);
        logic [15:0] ea;
        clearLogs();
        for (int r = 0; r < BUDGET; r++) begin
            @(posedge clk);
            #1;
            start = (r == 0) || (r == v.restart_at);
            if (r == 0) begin
                base_addr = v.base;
                length    = v.len;
`ifdef INPMEM_STREAM_STRIDE_EN
                stride    = v.stride;
`endif
            end else if (r == v.restart_at) begin
                base_addr = 16'h0ABC;
                length    = 16'd3;
            end
            out_ready = readyFor(v.ready_mode, r);
            @(negedge clk);
            sampleCycle(r);
            if (done_cyc >= 0 && r >= done_cyc + 3) break;
        end
        start     = 1'b0;
        out_ready = 1'b1;
        checkOutput({tag, "_timeout"}, done_cyc < 0, 0);
        checkOutput({tag, "_done_count"}, done_cnt, 1);
        checkOutput({tag, "_cen_cycles"}, addr_log.size(), v.len);
        checkOutput({tag, "_byte_count"}, data_log.size(), v.len);
        checkOutput({tag, "_inflight_ok"}, max_inflight <= 4, 1);
        checkOutput({tag, "_hold"}, hold_err, 0);
        checkOutput({tag, "_wen_d"}, wen_err, 0);
        for (int i = 0; i < int'(v.len); i++) begin
            ea = v.base + 16'(i * int'(v.stride));
            if (i < addr_log.size()) checkOutput($sformatf("%s_addr%0d", tag, i), addr_log[i], ea);
            if (i < data_log.size()) checkOutput($sformatf("%s_byte%0d", tag, i), data_log[i], ea[7:0]);
        end
        if (v.exp_done >= 0) begin
            checkOutput({tag, "_first_valid"}, first_valid, 3);
            checkOutput({tag, "_done_cycle"}, done_cyc, v.exp_done);
            checkOutput({tag, "_busy_fall"}, busy_fall, v.exp_done + 1);
        end
    endtask

    initial begin
        vec_t v;
        rst = 1'b1; start = 1'b0; base_addr = 16'h0; length = 16'h0; out_ready = 1'b1;
`ifdef INPMEM_STREAM_STRIDE_EN
        stride = 16'd1;
`endif
        //           base      len     stride mode restart done
        vecs.push_back('{16'h0010, 16'd8,  16'd1, 0, -1, 10});
        vecs.push_back('{16'h0040, 16'd16, 16'd1, 1, -1, -1});
        vecs.push_back('{16'hFFFE, 16'd4,  16'd1, 0, -1, 6});
        vecs.push_back('{16'h0200, 16'd32, 16'd1, 0, 5,  34});
        vecs.push_back('{16'h0007, 16'd1,  16'd1, 0, -1, 3});
        vecs.push_back('{16'h0300, 16'd9,  16'd1, 2, -1, -1});
`ifdef INPMEM_STREAM_STRIDE_EN
        vecs.push_back('{16'h0000, 16'd5,  16'd3, 0, -1, 7});
`endif

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_cen", mem_cen, 1);
        checkOutput("rst_wen", mem_wen, 1);
        checkOutput("rst_addr", mem_a, 0);
        checkOutput("rst_d", mem_d, 0);
        checkOutput("rst_valid", out_valid, 0);
        checkOutput("rst_data", out_data, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        foreach (vecs[k]) begin
            applyStimulus(vecs[k], $sformatf("vec%0d", k));
        end

        // Zero-length request: done the next cycle, no read issued.
        clearLogs();
        for (int r = 0; r < 4; r++) begin
            @(posedge clk);
            #1;
            start     = (r == 0);
            base_addr = 16'h1234;
            length    = 16'd0;
            @(negedge clk);
            sampleCycle(r);
        end
        start = 1'b0;
        checkOutput("zero_done_cycle", done_cyc, 1);
        checkOutput("zero_done_count", done_cnt, 1);
        checkOutput("zero_cen_cycles", addr_log.size(), 0);

        // Reset in cycle 5 of a 20-byte burst abandons it without done.
        clearLogs();
        for (int r = 0; r < 5; r++) begin
            @(posedge clk);
            #1;
            start     = (r == 0);
            base_addr = 16'h0500;
            length    = 16'd20;
            out_ready = 1'b1;
            @(negedge clk);
            sampleCycle(r);
        end
        start = 1'b0;
        checkOutput("mid_busy_before", busy, 1);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        checkOutput("mid_rst_cen", mem_cen, 1);
        checkOutput("mid_rst_valid", out_valid, 0);
        checkOutput("mid_rst_busy", busy, 0);
        for (int r = 5; r < 8; r++) begin
            @(negedge clk);
            sampleCycle(r);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        sampleCycle(8);
        checkOutput("mid_no_done", done_cnt, 0);
        checkOutput("mid_idle_cen", mem_cen, 1);

        v = '{16'h0100, 16'd4, 16'd1, 0, -1, 6};
        applyStimulus(v, "post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/inpmem_streamer.md
# inpmem_streamer

Read-side sequencer for the input memory bank. On `start` it issues a contiguous burst of single-byte reads (CEN low, WEN high) to the input memory, absorbs the memory's one-cycle read latency, and presents the returned bytes in address order on a valid/ready stream feeding the systolic array's input skew logic. It is the reader counterpart of the memory's write port. It never writes memory.

## Interface
Parameters:
- `ADDR_W`, 16, memory byte address width; equals the memory's addr_len + 8.
- `LEN_W`, 16, burst length counter width.
- `FIFO_DEPTH`, 4, return buffer depth; power of two, ≥ 4.

Ports:
- `clk`  in  1  single clock for the block and the memory.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `base_addr`  in  ADDR_W  first byte address; sampled with `start`.
- `length`  in  LEN_W  number of bytes to read; sampled with `start`.
- `busy`  out  1  high from the cycle after an accepted `start` until `done`.
- `done`  out  1  one-cycle pulse when the burst completes.
- `mem_cen`  out  1  memory chip enable, active low.
- `mem_wen`  out  1  memory write enable, active low; constant 1.
- `mem_a`  out  ADDR_W  memory address.
- `mem_d`  out  8  memory write data; constant 0.
- `mem_q`  in  8  memory read data; valid the cycle after `mem_cen` is low.
- `out_data`  out  8  stream data.
- `out_valid`  out  1  stream valid.
- `out_ready`  in  1  stream ready from the consumer.

## Operation
- FSM states and transitions:
  - IDLE: `start` with `length` != 0 → ISSUE. `start` with `length` == 0 → IDLE, `done` pulses the next cycle and no read is issued.
  - ISSUE: after the last read is issued → DRAIN.
  - DRAIN: after the last byte is accepted on the stream → IDLE, with `done` pulsing in the same cycle as the transition.
- Issue rule: a read is issued in a cycle only when the buffer occupancy plus the number of pending reads is less than `FIFO_DEPTH`. Pending reads are those issued but not yet written into the buffer; there are at most 2.
- When a read issues, the address register increments by 1 and the remaining count decrements by 1.
- Address wrap: addresses increment modulo 2^ADDR_W. The address after the all-ones address is 0, and this is not an error.
- Buffer write: `mem_q` is written into the buffer exactly one cycle after each issue cycle.
- Buffer read: an entry pops when `out_valid && out_ready`. A write and a pop can occur in the same cycle, and the occupancy is unchanged in that case.
- Ordering: stream order equals address order. No byte is dropped or duplicated under any `out_ready` pattern.
- `start` is ignored in ISSUE and DRAIN.
- `out_data` holds its value while `out_valid && !out_ready`.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `mem_cen`=1, `mem_wen`=1, `mem_a`=0, `mem_d`=0, `out_valid`=0, `out_data`=0. The buffer is emptied and pending reads are discarded.
- Reset asserted mid-burst has the same effect; the burst is abandoned, with no `done`.
- All `mem_*` outputs are driven from flops, because the memory delays its inputs internally and needs glitch-free drives.
- Latency: with `start` at cycle 0, `mem_cen`=0 and `mem_a`=`base_addr` in cycle 1, the buffer is written at the end of cycle 2, and `out_valid`=1 from cycle 3.
- Throughput: with `out_ready` held high, one byte per cycle is sustained.
- Completion: for N bytes with `out_ready` held high, the last byte is accepted in cycle N+2 and `done` pulses in cycle N+2. `busy` falls in cycle N+3.
- Backpressure: when `out_ready`=0, issuing stops once occupancy plus pending reaches `FIFO_DEPTH`. Issuing resumes the cycle after a pop frees space.

## Configuration
- `INPMEM_STREAM_STRIDE_EN`:
  - Defined: adds input `stride` [ADDR_W-1:0], which is sampled with `start`. The address increments by `stride` modulo 2^ADDR_W, and a stride of 0 reads the same byte `length` times.
  - Undefined: there is no `stride` port and the increment is fixed at 1.

## Structure
- `systola_pkg` contains:
  - the FSM state enum (IDLE, ISSUE, DRAIN);
  - the memory data width constant (8);
  - the constant for memory read latency (1), which is used to size the pending counter.
- `stream_fifo` is the one natural sub-module: a synchronous FIFO parameterised by width and depth, with occupancy output, simultaneous push/pop, and async reset.

## Test plan
- Basic burst: `base_addr`=0x0010, `length`=8, memory preloaded with byte = addr[7:0], `out_ready`=1 → stream 0x10..0x17 in cycles 3..10, `done` in cycle 10, `busy` low in cycle 11.
- Backpressure: `length`=16 with `out_ready` toggled 1,0,0,1 repeatedly → all 16 bytes in order, `mem_cen` low for exactly 16 cycles, occupancy never exceeds 4.
- Wrap-around: `base_addr`=0xFFFE, `length`=4 → addresses FFFE, FFFF, 0000, 0001 and the matching bytes.
- Zero length and ignored start: `length`=0 → `done` in cycle 1 and `mem_cen` stays 1. A second `start` during a 32-byte burst → no effect.
- Reset mid-burst: assert `rst` in cycle 5 of a 20-byte burst → `mem_cen`=1 and `out_valid`=0 immediately, no `done`. A following burst of 4 bytes from 0x0100 is correct.
- Stride (macro defined): `stride`=3, `base_addr`=0x0000, `length`=5 → addresses 0, 3, 6, 9, 12.
